// File: rtl/fetch_line_ctrl.sv
// Fetch line controller: requests I-cache lines, double-buffers them in
// line_reg / line_bak with one-line prefetch, and steers the PC and line muxes.
`timescale 1ns/1ps
module fetch_line_ctrl #(
    parameter int ICACHE_OFFSET = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     cache_ready_i,
    input  logic                     cache_valid_i,
    input  logic                     issue_ready_i,
    input  logic [ICACHE_OFFSET-1:0] pc_offset_i,
    output logic                     cache_req_o,
    output logic [1:0]               pc_sel_o,
    output logic [1:0]               line_sel_o,
    output logic                     line_reg_en_o,
    output logic                     line_bak_en_o,
    output logic                     instr_valid_o,
    output logic                     pc_adv_o
);

    localparam logic [1:0] PC_CUR   = 2'd0;
    localparam logic [1:0] PC_LINE  = 2'd2;
    localparam logic [1:0] LS_CACHE = 2'd0;
    localparam logic [1:0] LS_REG   = 2'd1;
    localparam logic [1:0] LS_BAK   = 2'd2;

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic   cur_buf_q, cur_buf_d;
    logic   pf_pend_q, pf_pend_d;
    logic   pf_valid_q, pf_valid_d;
    logic   discard_q, discard_d;

    logic       last_word;
    logic       accept;
    logic       req_fire;
    logic       fill_en;
    logic       fill_buf;
    logic [1:0] buf_sel;

    assign last_word = &pc_offset_i;
    assign accept    = instr_valid_o & issue_ready_i;
    assign pc_adv_o  = accept;
    assign req_fire  = cache_req_o & cache_ready_i;
    assign buf_sel   = cur_buf_q ? LS_BAK : LS_REG;

    // A line arriving from the cache is written into exactly one buffer.
    assign line_reg_en_o = fill_en & ~fill_buf;
    assign line_bak_en_o = fill_en &  fill_buf;

    always_comb begin
        cache_req_o   = 1'b0;
        pc_sel_o      = PC_CUR;
        line_sel_o    = LS_CACHE;
        instr_valid_o = 1'b0;
        fill_en       = 1'b0;
        fill_buf      = cur_buf_q;
        if (!flush_i) begin
            unique case (state_q)
                S_REQ: begin
                    cache_req_o = ~discard_q;
                end
                S_WAIT: begin
                    line_sel_o = buf_sel;
                    if (cache_valid_i && !discard_q) begin
                        line_sel_o    = LS_CACHE;
                        pc_sel_o      = PC_LINE;
                        instr_valid_o = 1'b1;
                        fill_en       = 1'b1;
                    end
                end
                S_STREAM: begin
                    instr_valid_o = 1'b1;
                    line_sel_o    = buf_sel;
                    cache_req_o   = ~pf_pend_q & ~pf_valid_q & ~discard_q;
                    if (cache_valid_i && pf_pend_q && !discard_q) begin
                        fill_en  = 1'b1;
                        fill_buf = ~cur_buf_q;
                    end
                end
                default: begin
                    cache_req_o = 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_buf_d  = cur_buf_q;
        pf_pend_d  = pf_pend_q;
        pf_valid_d = pf_valid_q;
        discard_d  = discard_q;
        if (flush_i) begin
            state_d    = S_REQ;
            cur_buf_d  = 1'b0;
            pf_pend_d  = 1'b0;
            pf_valid_d = 1'b0;
            // A response landing in the flush cycle itself retires the outstanding request.
            discard_d  = (discard_q | (state_q == S_WAIT) | pf_pend_q) & ~cache_valid_i;
        end else begin
            if (cache_valid_i && discard_q) begin
                discard_d = 1'b0;
            end
            unique case (state_q)
                S_REQ: begin
                    if (req_fire) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (fill_en) begin
                        state_d = (accept && last_word) ? S_REQ : S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (req_fire) begin
                        pf_pend_d = 1'b1;
                    end
                    if (fill_en) begin
                        pf_pend_d  = 1'b0;
                        pf_valid_d = 1'b1;
                    end
                    // Leaving the line: a request fired this cycle counts as pending.
                    if (accept && last_word) begin
                        cur_buf_d = ~cur_buf_q;
                        if (pf_valid_d) begin
                            pf_valid_d = 1'b0;
                        end else if (pf_pend_d) begin
                            pf_pend_d = 1'b0;
                            state_d   = S_WAIT;
                        end else begin
                            state_d = S_REQ;
                        end
                    end
                end
                default: begin
                    state_d = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q    <= S_REQ;
            cur_buf_q  <= 1'b0;
            pf_pend_q  <= 1'b0;
            pf_valid_q <= 1'b0;
            discard_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_buf_q  <= cur_buf_d;
            pf_pend_q  <= pf_pend_d;
            pf_valid_q <= pf_valid_d;
            discard_q  <= discard_d;
        end
    end

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Bench for fetch_line_ctrl: directed scenarios plus randomized traffic against
// a line-availability model with an in-bench I-cache responder.
`timescale 1ns/1ps
module tb_fetch_line_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       ready = 1'b0;
    logic       valid = 1'b0;
    logic       issue = 1'b0;
    logic [3:0] off = 4'd0;

    logic       cache_req_o;
    logic [1:0] pc_sel_o;
    logic [1:0] line_sel_o;
    logic       line_reg_en_o;
    logic       line_bak_en_o;
    logic       instr_valid_o;
    logic       pc_adv_o;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_line_ctrl #(.ICACHE_OFFSET(4)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .flush_i       (flush),
        .cache_ready_i (ready),
        .cache_valid_i (valid),
        .issue_ready_i (issue),
        .pc_offset_i   (off),
        .cache_req_o   (cache_req_o),
        .pc_sel_o      (pc_sel_o),
        .line_sel_o    (line_sel_o),
        .line_reg_en_o (line_reg_en_o),
        .line_bak_en_o (line_bak_en_o),
        .instr_valid_o (instr_valid_o),
        .pc_adv_o      (pc_adv_o)
    );

    // Packed view: {req, pc_sel, line_sel, reg_en, bak_en, instr_valid, pc_adv}
    function automatic logic [8:0] outs();
        return {cache_req_o, pc_sel_o, line_sel_o, line_reg_en_o, line_bak_en_o,
                instr_valid_o, pc_adv_o};
    endfunction

    task automatic apply(input logic f, input logic r, input logic v, input logic i,
                         input logic [3:0] o);
        @(negedge clk);
        flush = f; ready = r; valid = v; issue = i; off = o;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL reset_idle got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL reset_req got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b0_00_01_0_0_0_0) begin n_fail++; $display("FAIL reset_wait got %b want %b", outs(), 9'b0_00_01_0_0_0_0); end
        do_reset();
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL reset_drop got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
    endtask

    task automatic test_bypass();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL byp_req got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b0_00_01_0_0_0_0) begin n_fail++; $display("FAIL byp_wait got %b want %b", outs(), 9'b0_00_01_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b0_10_00_1_0_1_1) begin n_fail++; $display("FAIL byp_beat got %b want %b", outs(), 9'b0_10_00_1_0_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        n_chk++; if (outs() !== 9'b1_00_01_0_0_1_1) begin n_fail++; $display("FAIL byp_stream got %b want %b", outs(), 9'b1_00_01_0_0_1_1); end
    endtask

    task automatic test_prefetch_switch();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd1);
        n_chk++; if (outs() !== 9'b1_00_01_0_0_1_1) begin n_fail++; $display("FAIL pf_req got %b want %b", outs(), 9'b1_00_01_0_0_1_1); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd2);
        n_chk++; if (outs() !== 9'b0_00_01_0_1_1_1) begin n_fail++; $display("FAIL pf_fill got %b want %b", outs(), 9'b0_00_01_0_1_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        n_chk++; if (outs() !== 9'b0_00_01_0_0_1_1) begin n_fail++; $display("FAIL pf_last got %b want %b", outs(), 9'b0_00_01_0_0_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_10_0_0_1_1) begin n_fail++; $display("FAIL pf_switch got %b want %b", outs(), 9'b1_00_10_0_0_1_1); end
    endtask

    task automatic test_pending_last();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd14);
        n_chk++; if (outs() !== 9'b1_00_01_0_0_1_1) begin n_fail++; $display("FAIL pend_req got %b want %b", outs(), 9'b1_00_01_0_0_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd15);
        n_chk++; if (outs() !== 9'b0_00_01_0_0_1_1) begin n_fail++; $display("FAIL pend_last got %b want %b", outs(), 9'b0_00_01_0_0_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b0_00_10_0_0_0_0) begin n_fail++; $display("FAIL pend_gap got %b want %b", outs(), 9'b0_00_10_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b0_10_00_0_1_1_1) begin n_fail++; $display("FAIL pend_bypass got %b want %b", outs(), 9'b0_10_00_0_1_1_1); end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd1);
        n_chk++; if (outs() !== 9'b1_00_10_0_0_1_1) begin n_fail++; $display("FAIL pend_stream got %b want %b", outs(), 9'b1_00_10_0_0_1_1); end
    endtask

    task automatic test_stall();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b0_10_00_1_0_1_0) begin n_fail++; $display("FAIL stall_bypass got %b want %b", outs(), 9'b0_10_00_1_0_1_0); end
        for (int k = 0; k < 3; k++) begin
            apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd5);
            n_chk++; if (outs() !== 9'b1_00_01_0_0_1_0) begin n_fail++; $display("FAIL stall_%0d got %b want %b", k, outs(), 9'b1_00_01_0_0_1_0); end
        end
        apply(1'b0, 1'b0, 1'b0, 1'b1, 4'd5);
        n_chk++; if (outs() !== 9'b1_00_01_0_0_1_1) begin n_fail++; $display("FAIL stall_release got %b want %b", outs(), 9'b1_00_01_0_0_1_1); end
    endtask

    task automatic test_flush_wait();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        apply(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b0_00_00_0_0_0_0) begin n_fail++; $display("FAIL fw_flush got %b want %b", outs(), 9'b0_00_00_0_0_0_0); end
        apply(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b0_00_00_0_0_0_0) begin n_fail++; $display("FAIL fw_stale got %b want %b", outs(), 9'b0_00_00_0_0_0_0); end
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL fw_rereq got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        n_chk++; if (outs() !== 9'b0_10_00_1_0_1_1) begin n_fail++; $display("FAIL fw_bypass got %b want %b", outs(), 9'b0_10_00_1_0_1_1); end
    endtask

    task automatic test_flush_last();
        do_reset();
        apply(1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
        apply(1'b0, 1'b0, 1'b1, 1'b1, 4'd0);
        apply(1'b0, 1'b1, 1'b0, 1'b1, 4'd3);
        apply(1'b1, 1'b0, 1'b1, 1'b1, 4'd15);
        n_chk++; if (outs() !== 9'b0_00_00_0_0_0_0) begin n_fail++; $display("FAIL fl_flush got %b want %b", outs(), 9'b0_00_00_0_0_0_0); end
        apply(1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
        n_chk++; if (outs() !== 9'b1_00_00_0_0_0_0) begin n_fail++; $display("FAIL fl_req got %b want %b", outs(), 9'b1_00_00_0_0_0_0); end
    endtask

    // Model: which buffer holds the current line, whether the current and the
    // next line are on hand, and a queue of in-flight requests tagged stale.
    task automatic test_random();
        bit         q[$];
        int         cnt;
        logic [3:0] pc;
        bit         cur_have, next_have, mbuf;
        logic       f, r, v, i, fresh, stale_front, acc, last, fire;
        logic       e_req, e_reg, e_bak, e_val;
        logic [1:0] e_pc, e_ls, bsel;
        logic [8:0] exp_v;
        do_reset();
        cnt = 0; pc = 4'd0; cur_have = 0; next_have = 0; mbuf = 0;
        for (int c = 0; c < 3000; c++) begin
            f = (($urandom % 50) == 0);
            r = (($urandom % 3) != 0);
            i = (($urandom % 4) != 0);
            v = (q.size() != 0) && (cnt == 0);
            apply(f, r, v, i, pc);
            stale_front = (q.size() != 0) ? q[0] : 1'b0;
            fresh = v && !stale_front;
            bsel = mbuf ? 2'd2 : 2'd1;
            e_req = 0; e_pc = 2'd0; e_ls = 2'd0; e_reg = 0; e_bak = 0; e_val = 0;
            if (!f) begin
                if (!cur_have) begin
                    if (fresh) begin
                        e_pc = 2'd2; e_val = 1;
                        if (mbuf) e_bak = 1; else e_reg = 1;
                    end else begin
                        e_req = (q.size() == 0);
                        e_ls = (q.size() != 0 && !stale_front) ? bsel : 2'd0;
                    end
                end else begin
                    e_val = 1; e_ls = bsel;
                    e_req = (q.size() == 0) && !next_have;
                    if (fresh) begin
                        if (mbuf) e_reg = 1; else e_bak = 1;
                    end
                end
            end
            acc = e_val && i;
            last = (pc == 4'hF);
            exp_v = {e_req, e_pc, e_ls, e_reg, e_bak, e_val, acc};
            n_chk++;
            if (outs() !== exp_v) begin
                n_fail++;
                $display("FAIL rand_cycle_%0d got %b want %b", c, outs(), exp_v);
            end
            fire = cache_req_o && r;
            if (v) void'(q.pop_front());
            else if (q.size() != 0 && cnt > 0) cnt--;
            if (f) begin
                for (int k = 0; k < q.size(); k++) q[k] = 1'b1;
                cur_have = 0; next_have = 0; mbuf = 0;
                pc = 4'($urandom);
            end else begin
                if (!cur_have) begin
                    if (fresh) cur_have = !(acc && last);
                end else begin
                    if (fresh) next_have = 1;
                    if (acc && last) begin
                        mbuf = ~mbuf;
                        if (next_have) next_have = 0;
                        else cur_have = 0;
                    end
                end
                if (acc) pc = pc + 4'd1;
            end
            if (fire) begin
                q.push_back(1'b0);
                cnt = int'($urandom_range(0, 3));
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_prefetch_switch();
        test_pending_last();
        test_stall();
        test_flush_wait();
        test_flush_last();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_line_ctrl.md
FETCH_LINE_CTRL -- requirements
Module: fetch_line_ctrl

Interface
REQ-001 Parameter ICACHE_OFFSET, default 4, log2 of instructions per cache line.
REQ-002 clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n_i  input  1  reset, synchronous, active-low.
REQ-004 flush_i  input  1  redirect: discard all line state and restart fetch at the new PC.
REQ-005 cache_ready_i  input  1  I-cache accepts the request this cycle.
REQ-006 cache_valid_i  input  1  I-cache returns one line this cycle (single-cycle pulse).
REQ-007 issue_ready_i  input  1  downstream accepts instr_valid_o this cycle.
REQ-008 pc_offset_i  input  ICACHE_OFFSET  word offset of the current fetch PC within its line.
REQ-009 cache_req_o  output  1  line request to I-cache.
REQ-010 pc_sel_o  output  2  PC mux select: 0 current_pc, 1 prev_pc, 2 line_pc.
REQ-011 line_sel_o  output  2  line mux select: 0 cache_out, 1 line_reg, 2 line_bak.
REQ-012 line_reg_en_o  output  1  load enable of line_reg from cache output.
REQ-013 line_bak_en_o  output  1  load enable of line_bak from cache output.
REQ-014 instr_valid_o  output  1  selected instruction is valid.
REQ-015 pc_adv_o  output  1  advance fetch PC by one instruction.

Function
REQ-016 FSM states: REQ, WAIT, STREAM.
REQ-017 Internal state: cur_buf (0 = line_reg, 1 = line_bak), pf_pend, pf_valid, discard.
REQ-018 Last word: pc_offset_i equals all ones.
REQ-019 Accept: instr_valid_o and issue_ready_i both high.
REQ-020 pc_adv_o equals accept, combinationally.
REQ-021 REQ: cache_req_o = 1, instr_valid_o = 0; cache_ready_i -> WAIT.
REQ-022 WAIT, cache_valid_i low: all outputs 0 except select defaults (pc_sel 0, line_sel per cur_buf).
REQ-023 WAIT, cache_valid_i high and discard low (bypass beat):
- line_sel_o = 0, pc_sel_o = 2, instr_valid_o = 1
- enable of buffer cur_buf (line_reg_en_o if 0, line_bak_en_o if 1) = 1
- next state: REQ if accept on last word, else STREAM.
REQ-024 STREAM: instr_valid_o = 1, pc_sel_o = 0, line_sel_o = 1 if cur_buf = 0, else 2.
REQ-025 STREAM prefetch: cache_req_o = 1 while pf_pend = 0 and pf_valid = 0; cache_ready_i then sets pf_pend.
REQ-026 STREAM, cache_valid_i with pf_pend and discard low:
- enable of the non-current buffer pulses
- pf_valid set, pf_pend cleared.
REQ-027 STREAM, accept on last word:
- pf_valid: toggle cur_buf, clear pf_valid, stay in STREAM
- pf_pend only: -> WAIT with cur_buf toggled, bypass via REQ-023
- neither: toggle cur_buf, -> REQ.
REQ-028 Prefetch return and last-word accept in the same cycle: the returned line is written to the non-current buffer and the REQ-027 pf_valid branch is taken.
REQ-029 Not accepted (issue_ready_i low): state, cur_buf and the selects hold; instr_valid_o stays 1.
REQ-030 Flush has priority over every same-cycle event:
- next state REQ; cur_buf, pf_pend, pf_valid cleared
- during the flush cycle instr_valid_o, pc_adv_o, all enables and cache_req_o are 0.
REQ-031 Discard on flush: discard is set if a request is outstanding (state WAIT, pf_pend set, or cache_req_o and cache_ready_i in the flush cycle).
REQ-032 The next cache_valid_i after a flush with discard set is dropped (no enable, no valid) and clears discard.
REQ-033 At most one request is outstanding at any time; cache_req_o is held 0 while discard is set.
REQ-034 pc_sel_o value 1 and line_sel_o value 3 are never driven.

Reset
REQ-035 When rst_n_i is low at a clock edge:
- state REQ; cur_buf, pf_pend, pf_valid, discard = 0
- outputs next cycle: cache_req_o = 1, all others 0, selects 0.
REQ-036 Reset mid-transfer drops all pending responses.

Verification
REQ-037 Reset, cache_ready_i = 1, cache_valid_i 2 cycles later, offset 0, issue_ready_i = 1 -> bypass beat: line_sel 0, pc_sel 2, line_reg_en 1, pc_adv 1; then STREAM with line_sel 1.
REQ-038 STREAM, prefetch returned, accept at offset 15 -> line_bak_en earlier, then line_sel switches 1 -> 2 next cycle with no instr_valid gap.
REQ-039 Last word accepted with prefetch still pending -> instr_valid 0 until cache_valid, then bypass beat with line_bak_en 1.
REQ-040 issue_ready_i low for 3 cycles in STREAM -> instr_valid 1, pc_adv 0, selects constant.
REQ-041 Flush in WAIT, stale cache_valid 1 cycle later -> response dropped, REQ re-entered, the next response is accepted as a bypass beat.
REQ-042 Flush in the same cycle as a last-word accept and cache_valid_i -> no enable, no pc_adv; state REQ.
